// File: rtl/axi_lite_regfile_pkg.sv
// Shared types, response codes and address decode for the AXI4-Lite register file.
// Build option: AXI_LITE_REGFILE_DECERR_EN makes out-of-range accesses return DECERR.
package axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_LITE_REGFILE_DECERR_EN
  localparam logic [1:0] RESP_OOR = RESP_DECERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  typedef enum logic [1:0] {WIDLE, WAITW, WAITAW, WRESP} write_state_t;
  typedef enum logic       {RIDLE, RRESP} read_state_t;

  typedef struct packed {
    logic        in_range;
    logic [31:0] idx;
  } reg_sel_t;

  // Word index of a byte address; sub-word address bits are dropped.
  function automatic reg_sel_t addr_to_idx(input logic [63:0] addr,
                                           input int unsigned addr_lsb,
                                           input int unsigned n_regs);
    logic [63:0] word;
    reg_sel_t    sel;
    word         = addr >> addr_lsb;
    sel.in_range = (word < 64'(n_regs));
    sel.idx      = word[31:0];
    return sel;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_regfile_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_regfile_wfsm.sv
// Write-side FSM: accepts AW and W in either order, emits a single-cycle commit
// strobe on the second handshake and returns the B response.
module axi_lite_regfile_wfsm
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned N_REGS         = 16,
  localparam int unsigned STRB_W        = AXI_DATA_WIDTH / 8,
  localparam int unsigned IDX_W         = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
  input  logic [STRB_W-1:0]         w_strb_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  output logic [1:0]                b_resp_o,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic                      commit_c_o,
  output logic                      commit_hit_c_o,
  output logic [IDX_W-1:0]          commit_idx_c_o,
  output logic [AXI_DATA_WIDTH-1:0] commit_data_c_o,
  output logic [STRB_W-1:0]         commit_strb_c_o
);

  localparam int unsigned ADDR_LSB = $clog2(STRB_W);

  write_state_t              state_q, state_d;
  logic                      aw_ready_q, aw_ready_d;
  logic                      w_ready_q, w_ready_d;
  logic                      b_valid_q, b_valid_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]         strb_q, strb_d;

  logic                      aw_fire_c, w_fire_c;
  logic [AXI_ADDR_WIDTH-1:0] cmt_addr_c;
  reg_sel_t                  cmt_sel_c;

  assign aw_fire_c  = aw_valid_i & aw_ready_q;
  assign w_fire_c   = w_valid_i & w_ready_q;
  // Whichever half arrived first comes from the latch, the other straight off the bus.
  assign cmt_addr_c = (state_q == WAITW) ? addr_q : aw_addr_i;
  assign cmt_sel_c  = addr_to_idx(64'(cmt_addr_c), ADDR_LSB, N_REGS);

  assign commit_hit_c_o  = cmt_sel_c.in_range;
  assign commit_idx_c_o  = IDX_W'(cmt_sel_c.idx);
  assign commit_data_c_o = (state_q == WAITAW) ? data_q : w_data_i;
  assign commit_strb_c_o = (state_q == WAITAW) ? strb_q : w_strb_i;

  always_comb begin
    state_d    = state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    commit_c_o = 1'b0;
    case (state_q)
      WIDLE: begin
        if (aw_fire_c && w_fire_c) begin
          commit_c_o = 1'b1;
        end else if (aw_fire_c) begin
          addr_d     = aw_addr_i;
          aw_ready_d = 1'b0;
          state_d    = WAITW;
        end else if (w_fire_c) begin
          data_d    = w_data_i;
          strb_d    = w_strb_i;
          w_ready_d = 1'b0;
          state_d   = WAITAW;
        end
      end
      WAITW:  commit_c_o = w_fire_c;
      WAITAW: commit_c_o = aw_fire_c;
      WRESP: begin
        if (b_ready_i) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          state_d    = WIDLE;
        end
      end
      default: state_d = WIDLE;
    endcase
    if (commit_c_o) begin
      b_valid_d  = 1'b1;
      b_resp_d   = cmt_sel_c.in_range ? RESP_OKAY : RESP_OOR;
      aw_ready_d = 1'b0;
      w_ready_d  = 1'b0;
      state_d    = WRESP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WIDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_resp_o   = b_resp_q;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: byte-strobed writes, one-cycle reads, exported
// register contents and per-register write pulses.
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned N_REGS         = 16
) (
  input  logic                                   Clk_CI,
  input  logic                                   Rst_RBI,
  axi_lite_regfile_if.slave                      AxiLite_PS,
  output logic [N_REGS-1:0][AXI_DATA_WIDTH-1:0]  Regs_DO,
  output logic [N_REGS-1:0]                      WrPulse_SO
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic [N_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [N_REGS-1:0]                     pulse_q, pulse_d;

  logic                      cmt_c, cmt_hit_c;
  logic [IDX_W-1:0]          cmt_idx_c;
  logic [AXI_DATA_WIDTH-1:0] cmt_data_c;
  logic [STRB_W-1:0]         cmt_strb_c;

  axi_lite_regfile_wfsm #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .N_REGS         (N_REGS)
  ) u_wfsm (
    .clk             (Clk_CI),
    .rst_n           (Rst_RBI),
    .aw_addr_i       (AxiLite_PS.aw_addr),
    .aw_valid_i      (AxiLite_PS.aw_valid),
    .aw_ready_o      (AxiLite_PS.aw_ready),
    .w_data_i        (AxiLite_PS.w_data),
    .w_strb_i        (AxiLite_PS.w_strb),
    .w_valid_i       (AxiLite_PS.w_valid),
    .w_ready_o       (AxiLite_PS.w_ready),
    .b_resp_o        (AxiLite_PS.b_resp),
    .b_valid_o       (AxiLite_PS.b_valid),
    .b_ready_i       (AxiLite_PS.b_ready),
    .commit_c_o      (cmt_c),
    .commit_hit_c_o  (cmt_hit_c),
    .commit_idx_c_o  (cmt_idx_c),
    .commit_data_c_o (cmt_data_c),
    .commit_strb_c_o (cmt_strb_c)
  );

  // Storage update; a zero strobe still counts as a write for the pulse.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (cmt_c && cmt_hit_c) begin
      pulse_d[cmt_idx_c] = 1'b1;
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (cmt_strb_c[b]) regs_d[cmt_idx_c][b*8 +: 8] = cmt_data_c[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  read_state_t               rstate_q, rstate_d;
  logic                      ar_ready_q, ar_ready_d;
  logic                      r_valid_q, r_valid_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d;
  reg_sel_t                  ar_sel_c;
  logic [IDX_W-1:0]          ar_idx_c;

  assign ar_sel_c = addr_to_idx(64'(AxiLite_PS.ar_addr), ADDR_LSB, N_REGS);
  assign ar_idx_c = IDX_W'(ar_sel_c.idx);

  // Read data samples regs_q, so a same-cycle write commit is not yet visible.
  always_comb begin
    rstate_d   = rstate_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rstate_q)
      RIDLE: begin
        if (AxiLite_PS.ar_valid && ar_ready_q) begin
          r_data_d   = ar_sel_c.in_range ? regs_q[ar_idx_c] : '0;
          r_resp_d   = ar_sel_c.in_range ? RESP_OKAY : RESP_OOR;
          r_valid_d  = 1'b1;
          ar_ready_d = 1'b0;
          rstate_d   = RRESP;
        end
      end
      RRESP: begin
        if (AxiLite_PS.r_ready) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          rstate_d   = RIDLE;
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rstate_q   <= RIDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      rstate_q   <= rstate_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign AxiLite_PS.ar_ready = ar_ready_q;
  assign AxiLite_PS.r_valid  = r_valid_q;
  assign AxiLite_PS.r_data   = r_data_q;
  assign AxiLite_PS.r_resp   = r_resp_q;
  assign Regs_DO             = regs_q;
  assign WrPulse_SO          = pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile (32-bit data, 16 registers).
module tb_axi_lite_regfile;

`ifdef AXI_LITE_REGFILE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic              clk;
  logic              rst_n;
  logic [15:0][31:0] regs;
  logic [15:0]       pulse;
  int                n_chk;
  int                n_pass;

  axi_lite_regfile_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  axi_lite_regfile #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .N_REGS         (16)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (rst_n),
    .AxiLite_PS (bus.slave),
    .Regs_DO    (regs),
    .WrPulse_SO (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_drain();
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.aw_addr = addr; bus.aw_valid = 1'b1;
    bus.w_data = data;  bus.w_strb = strb; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    b_drain();
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    bus.ar_addr = addr; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    chk({tag, "_rvalid"}, 64'(bus.r_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(bus.r_data), 64'(exp_data));
    chk({tag, "_rresp"}, 64'(bus.r_resp), 64'(exp_resp));
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    chk({tag, "_rdone"}, 64'(bus.r_valid), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0;  bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_awready", 64'(bus.aw_ready), 64'd1);
    chk("rst_wready", 64'(bus.w_ready), 64'd1);
    chk("rst_arready", 64'(bus.ar_ready), 64'd1);
    chk("rst_bvalid", 64'(bus.b_valid), 64'd0);
    chk("rst_rvalid", 64'(bus.r_valid), 64'd0);
    chk("rst_resps", 64'({bus.b_resp, bus.r_resp}), 64'd0);
    chk("rst_rdata", 64'(bus.r_data), 64'd0);
    chk("rst_regs_any", 64'(|regs), 64'd0);
    chk("rst_pulse", 64'(pulse), 64'd0);

    // Simultaneous AW+W to reg2
    bus.aw_addr = 32'h8; bus.aw_valid = 1'b1;
    bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("t1_bvalid", 64'(bus.b_valid), 64'd1);
    chk("t1_bresp", 64'(bus.b_resp), 64'd0);
    chk("t1_reg2", 64'(regs[2]), 64'hDEADBEEF);
    chk("t1_pulse", 64'(pulse), 64'h0004);
    chk("t1_awready", 64'(bus.aw_ready), 64'd0);
    tick();
    chk("t1_pulse_once", 64'(pulse), 64'h0000);
    chk("t1_bhold", 64'(bus.b_valid), 64'd1);
    b_drain();
    chk("t1_bdone", 64'(bus.b_valid), 64'd0);
    chk("t1_idle_ready", 64'({bus.aw_ready, bus.w_ready}), 64'h3);

    // AW first, W three cycles later, byte-0 only
    wr(32'h4, 32'h11223344, 4'hF);
    bus.aw_addr = 32'h4; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    chk("t2_waitw_ready", 64'({bus.aw_ready, bus.w_ready}), 64'h1);
    tick(); tick();
    bus.w_data = 32'h000000AA; bus.w_strb = 4'h1; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("t2_bvalid", 64'(bus.b_valid), 64'd1);
    chk("t2_reg1", 64'(regs[1]), 64'h112233AA);
    chk("t2_pulse", 64'(pulse), 64'h0002);
    b_drain();

    // W first, AW two cycles later to reg3
    bus.w_data = 32'hCAFEF00D; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("t3_waitaw_ready", 64'({bus.aw_ready, bus.w_ready}), 64'h2);
    chk("t3_no_write_yet", 64'(regs[3]), 64'h0);
    tick();
    bus.aw_addr = 32'hC; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    chk("t3_bvalid", 64'(bus.b_valid), 64'd1);
    chk("t3_bresp", 64'(bus.b_resp), 64'd0);
    chk("t3_reg3", 64'(regs[3]), 64'hCAFEF00D);
    b_drain();

    // Zero strobe: no data change but still a pulse
    bus.aw_addr = 32'h8; bus.aw_valid = 1'b1;
    bus.w_data = 32'h12345678; bus.w_strb = 4'h0; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("t4_reg2_kept", 64'(regs[2]), 64'hDEADBEEF);
    chk("t4_pulse", 64'(pulse), 64'h0004);
    b_drain();

    // Out-of-range write and read
    bus.aw_addr = 32'h40; bus.aw_valid = 1'b1;
    bus.w_data = 32'h55555555; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("t5_bresp", 64'(bus.b_resp), 64'(OOR_RESP));
    chk("t5_pulse", 64'(pulse), 64'h0000);
    chk("t5_reg0", 64'(regs[0]), 64'h0);
    b_drain();
    rd("t5_rd", 32'h40, 32'h0, OOR_RESP);

    // Reads, including ignored sub-word address bits
    rd("t6_rd2", 32'hB, 32'hDEADBEEF, 2'b00);
    rd("t6_rd1", 32'h4, 32'h112233AA, 2'b00);

    // AR and write commit to reg5 in the same cycle
    wr(32'h14, 32'h5, 4'hF);
    bus.aw_addr = 32'h14; bus.aw_valid = 1'b1;
    bus.w_data = 32'h6; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.ar_addr = 32'h14; bus.ar_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    chk("t7_old_rdata", 64'(bus.r_data), 64'h5);
    chk("t7_reg5_new", 64'(regs[5]), 64'h6);
    bus.r_ready = 1'b1;
    b_drain();
    bus.r_ready = 1'b0;
    rd("t7_rd5", 32'h14, 32'h6, 2'b00);

    // Stall both responses, then reset mid-transaction
    bus.aw_addr = 32'h0; bus.aw_valid = 1'b1;
    bus.w_data = 32'h77; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.ar_addr = 32'h8; bus.ar_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    repeat (10) tick();
    chk("t8_stall_valids", 64'({bus.b_valid, bus.r_valid}), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_async_valids", 64'({bus.b_valid, bus.r_valid}), 64'h0);
    chk("t8_async_ready", 64'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 64'h7);
    chk("t8_async_regs", 64'(|regs), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rd("t8_rd0", 32'h0, 32'h0, 2'b00);
    rd("t8_rd2", 32'h8, 32'h0, 2'b00);
    chk("t8_bvalid_dropped", 64'(bus.b_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
